// File: rtl/pisa_bus_pkg.sv
// Shared types and constants for the two-requester system memory bus arbiter.
package pisa_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } pisa_arb_state_t;

    localparam logic ARB_M_CORE = 1'b0;
    localparam logic ARB_M_DBG  = 1'b1;

    localparam int unsigned LAT_W = 4;

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// Two-way round-robin pick: on a tie the requester that did not own the bus last wins.
module rr_arbiter_2
    import pisa_bus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] pick
);

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = (last_grant == ARB_M_DBG) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single-port memory bus between the Core and the debug/DMA port,
// one word per access with a fixed memory latency.
module mem_bus_arbiter
    import pisa_bus_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        m_req,
    input  logic [1:0]        m_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [1:0]        m_gnt,
    output logic [1:0]        m_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              grant_id,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_data_in
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("mem_bus_arbiter: MEM_LATENCY must be within 1..15");
    end

    localparam logic [LAT_W-1:0] LAT_END = LAT_W'(MEM_LATENCY);

    pisa_arb_state_t  state;
    logic             last_grant;
    logic             owner;
    logic             owner_we;
    logic [LAT_W-1:0] cnt;
    logic [1:0]       pick;

    rr_arbiter_2 u_rr (
        .req        (m_req),
        .last_grant (last_grant),
        .pick       (pick)
    );

    // Outputs are registered one state ahead, so each is valid in the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            last_grant       <= ARB_M_DBG;
            owner            <= ARB_M_CORE;
            owner_we         <= 1'b0;
            cnt              <= '0;
            m_gnt            <= '0;
            m_ack            <= '0;
            rdata            <= '0;
            grant_id         <= 1'b0;
            busy             <= 1'b0;
            mem_address      <= '0;
            mem_data_out     <= '0;
            mem_write_enable <= 1'b0;
        end else begin
            m_gnt            <= '0;
            m_ack            <= '0;
            mem_write_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick != 2'b00) begin
                        if (pick[ARB_M_DBG]) begin
                            mem_address      <= m1_addr;
                            mem_data_out     <= m1_wdata;
                            owner_we         <= m_we[ARB_M_DBG];
                            mem_write_enable <= m_we[ARB_M_DBG];
                        end else begin
                            mem_address      <= m0_addr;
                            mem_data_out     <= m0_wdata;
                            owner_we         <= m_we[ARB_M_CORE];
                            mem_write_enable <= m_we[ARB_M_CORE];
                        end
                        owner      <= pick[ARB_M_DBG];
                        last_grant <= pick[ARB_M_DBG];
                        grant_id   <= pick[ARB_M_DBG];
                        m_gnt      <= pick;
                        busy       <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    cnt   <= LAT_W'(1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == LAT_END) begin
                        if (!owner_we) begin
                            rdata <= mem_data_in;
                        end
                        m_ack <= owner ? 2'b10 : 2'b01;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + LAT_W'(1);
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
